// File: rtl/nfu_1_seq.sv
// NFU-1 sequencer: walks the output-tile x input-tile loop nest, strobes NBin/SB
// reads and presents the resulting products to NFU-2 with first/last markers.
//
// state | meaning
// IDLE  | waiting for i_start, config latched on start
// RUN   | issuing one NBin/SB read per accepted step
// DRAIN | all reads issued, waiting for the final beat to be accepted
// DONE  | one-cycle completion pulse
module nfu_1_seq #(
  parameter int BIT_WIDTH = 16,
  parameter int Tn        = 16,
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_num_in,
  input  logic [CNT_W-1:0]  i_num_out,
  input  logic [ADDR_W-1:0] i_nbin_base,
  input  logic [ADDR_W-1:0] i_sb_base,
  input  logic              i_ready,
  output logic              o_nbin_rd_en,
  output logic [ADDR_W-1:0] o_nbin_addr,
  output logic              o_sb_rd_en,
  output logic [ADDR_W-1:0] o_sb_addr,
  output logic              o_valid,
  output logic              o_first,
  output logic              o_last,
  output logic [CNT_W-1:0]  o_out_idx,
  output logic              o_busy,
  output logic              o_done
);

  // Datapath width and tile size describe the array this block feeds; nothing here depends on them.
  if (BIT_WIDTH > 0 && Tn > 0) begin : g_array_geometry
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    num_in_q, num_in_d;
  logic [CNT_W-1:0]    num_out_q, num_out_d;
  logic [ADDR_W-1:0]   nbin_base_q, nbin_base_d;
  logic [ADDR_W-1:0]   sb_ptr_q, sb_ptr_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                valid_q, valid_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    out_idx_q, out_idx_d;

  logic issue;
  logic in_last;
  logic out_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      num_in_q    <= '0;
      num_out_q   <= '0;
      nbin_base_q <= '0;
      sb_ptr_q    <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      num_in_q    <= num_in_d;
      num_out_q   <= num_out_d;
      nbin_base_q <= nbin_base_d;
      sb_ptr_q    <= sb_ptr_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      out_idx_q   <= out_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_in_d    = num_in_q;
    num_out_d   = num_out_q;
    nbin_base_d = nbin_base_q;
    sb_ptr_d    = sb_ptr_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    valid_d     = valid_q;
    first_d     = first_q;
    last_d      = last_q;
    out_idx_d   = out_idx_q;

    issue    = (state_q == S_RUN) && (!valid_q || i_ready);
    in_last  = (in_cnt_q == num_in_q - CNT_W'(1));
    out_last = (out_cnt_q == num_out_q - CNT_W'(1));

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          num_in_d    = i_num_in;
          num_out_d   = i_num_out;
          nbin_base_d = i_nbin_base;
          sb_ptr_d    = i_sb_base;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          // An empty job passes through DRAIN (nothing pending) so o_done lands two cycles after start.
          if (i_num_in == '0 || i_num_out == '0) state_d = S_DRAIN;
          else                                   state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issue && in_last && out_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!valid_q || i_ready) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      sb_ptr_d  = sb_ptr_q + ADDR_W'(1);
      valid_d   = 1'b1;
      first_d   = (in_cnt_q == '0);
      last_d    = in_last;
      out_idx_d = out_cnt_q;
      if (in_last) begin
        in_cnt_d  = '0;
        out_cnt_d = out_cnt_q + CNT_W'(1);
      end else begin
        in_cnt_d  = in_cnt_q + CNT_W'(1);
      end
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  assign o_nbin_rd_en = issue;
  assign o_sb_rd_en   = issue;
  assign o_nbin_addr  = issue ? nbin_base_q + ADDR_W'(in_cnt_q) : '0;
  assign o_sb_addr    = issue ? sb_ptr_q : '0;
  assign o_valid      = valid_q;
  assign o_first      = first_q;
  assign o_last       = last_q;
  assign o_out_idx    = out_idx_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_nfu_1_seq.sv
// Scoreboard bench for nfu_1_seq: jobs push expected beats, a negedge monitor
// pops and compares whenever a beat is accepted.
module tb_nfu_1_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [7:0]  i_num_in, i_num_out;
  logic [9:0]  i_nbin_base, i_sb_base;
  logic        i_ready;
  logic        o_nbin_rd_en, o_sb_rd_en;
  logic [9:0]  o_nbin_addr, o_sb_addr;
  logic        o_valid, o_first, o_last, o_busy, o_done;
  logic [7:0]  o_out_idx;

  nfu_1_seq #(.BIT_WIDTH(16), .Tn(16), .ADDR_W(10), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_num_in(i_num_in), .i_num_out(i_num_out),
    .i_nbin_base(i_nbin_base), .i_sb_base(i_sb_base), .i_ready(i_ready),
    .o_nbin_rd_en(o_nbin_rd_en), .o_nbin_addr(o_nbin_addr),
    .o_sb_rd_en(o_sb_rd_en), .o_sb_addr(o_sb_addr),
    .o_valid(o_valid), .o_first(o_first), .o_last(o_last),
    .o_out_idx(o_out_idx), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] nb;
    logic [9:0] sb;
    logic       first;
    logic       last;
    logic [7:0] idx;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    done_cyc = 0;
  bit    done_seen = 0;
  int    strobes = 0;
  int    beats = 0;
  logic [9:0] beat_nb = '0, beat_sb = '0;
  beat_t prev_beat = '0;
  bit    prev_valid = 0, prev_ready = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: beat data is the address pair of the most recent strobe before the beat.
  always @(negedge clk) begin
    beat_t cur, e;
    if (!rst_n) begin
      prev_valid = 0;
    end else begin
      cur = {beat_nb, beat_sb, o_first, o_last, o_out_idx};
      if (o_nbin_rd_en || o_sb_rd_en) chk("rd_en_pair", o_sb_rd_en, o_nbin_rd_en);
      if (o_valid && !i_ready) chk("stall_strobe", o_nbin_rd_en, 1'b0);
      if (o_valid && prev_valid && !prev_ready) chk("beat_hold", cur, prev_beat);
      if (o_valid && i_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", cur, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
        end
      end
      if (o_nbin_rd_en) begin
        strobes++;
        beat_nb = o_nbin_addr;
        beat_sb = o_sb_addr;
      end
      if (o_done && !done_seen) begin
        done_seen = 1;
        done_cyc  = cyc - start_cyc;
      end
      prev_valid = o_valid;
      prev_ready = i_ready;
      prev_beat  = cur;
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, {o_nbin_rd_en, o_nbin_addr, o_sb_rd_en, o_sb_addr, o_valid,
               o_first, o_last, o_out_idx, o_busy, o_done}, 64'd0);
  endtask

  task automatic push_job(input logic [7:0] ni, input logic [7:0] no,
                          input logic [9:0] nb, input logic [9:0] sb);
    beat_t b;
    logic [9:0] sp;
    sp = sb;
    for (int o = 0; o < int'(no); o++)
      for (int i = 0; i < int'(ni); i++) begin
        b.nb    = nb + 10'(i);
        b.sb    = sp;
        b.first = (i == 0);
        b.last  = (i == int'(ni) - 1);
        b.idx   = 8'(o);
        exp_q.push_back(b);
        sp = sp + 10'd1;
      end
  endtask

  task automatic run_job(input string name, input logic [7:0] ni, input logic [7:0] no,
                         input logic [9:0] nb, input logic [9:0] sb, input int exp_done,
                         input int stall_lo, input int stall_hi, input bit inject_start);
    int n;
    n = int'(ni) * int'(no);
    push_job(ni, no, nb, sb);
    strobes = 0;
    beats = 0;
    done_seen = 0;
    @(posedge clk); #1;
    i_num_in = ni; i_num_out = no; i_nbin_base = nb; i_sb_base = sb;
    i_start = 1'b1;
    i_ready = 1'b1;
    start_cyc = cyc;
    for (int r = 1; r <= 80; r++) begin
      @(posedge clk); #1;
      i_start = inject_start && (r == 1);
      if (r == 1) begin
        i_num_in = 8'd5; i_num_out = 8'd5; i_nbin_base = 10'h155; i_sb_base = 10'h2AA;
      end
      i_ready = !(r >= stall_lo && r <= stall_hi);
      if (done_seen) break;
    end
    i_start = 1'b0;
    i_ready = 1'b1;
    if (!done_seen) chk({name, "_done_timeout"}, 0, 1);
    else            chk({name, "_done_cycle"}, done_cyc, exp_done);
    chk({name, "_idle_after_done"}, o_busy, 1'b0);
    chk({name, "_strobes"}, strobes, n);
    chk({name, "_beats"}, beats, n);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_ready = 1'b1;
    i_num_in = '0; i_num_out = '0; i_nbin_base = '0; i_sb_base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;

    // basic 3x2 nest: NBin 10,11,12,10,11,12; SB 40..45; done in cycle 8
    run_job("basic", 8'd3, 8'd2, 10'h010, 10'h040, 8, 0, -1, 0);
    // ready low cycles 3-5: beat 1 held three cycles, done slips to 11
    run_job("backpressure", 8'd3, 8'd2, 10'h010, 10'h040, 11, 3, 5, 0);
    run_job("single", 8'd1, 8'd1, 10'h020, 10'h030, 3, 0, -1, 0);
    // empty job with a stray start while busy
    run_job("zero", 8'd3, 8'd0, 10'h010, 10'h040, 2, 0, -1, 1);
    // SB pointer wraps 3FE,3FF,000,001
    run_job("wrap", 8'd4, 8'd1, 10'h000, 10'h3FE, 6, 0, -1, 0);

    // reset during beat 2 of a 3x2 job
    push_job(8'd3, 8'd2, 10'h010, 10'h040);
    strobes = 0; beats = 0; done_seen = 0;
    @(posedge clk); #1;
    i_num_in = 8'd3; i_num_out = 8'd2; i_nbin_base = 10'h010; i_sb_base = 10'h040;
    i_start = 1'b1; start_cyc = cyc;
    for (int r = 1; r <= 4; r++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    chk("pre_reset_beat2_valid", {o_valid, o_out_idx, o_last}, {1'b1, 8'd0, 1'b1});
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("midjob_reset_outputs");
    chk("midjob_beats_before_reset", beats, 2);
    rst_n = 1'b1;
    exp_q.delete();
    run_job("after_reset", 8'd3, 8'd2, 10'h010, 10'h040, 8, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
